gray_step_arbiter: RTL and testbench
====================================

# gray_step_arbiter

Sequencing controller for the 3-bit Gray-code counter (`Clk`, `Reset`, `En` in; 3-bit `Output`, sticky `Overflow` out). It shares one counter instance between two requesters. Each requester asks for an optional clear plus a number of count steps. The arbiter grants round-robin, drives the counter's `En`/`Reset`, counts the steps, watches for wrap-around, and returns the final Gray value with a one-cycle acknowledge.

## Interface
Parameters:
- `STEP_W`, default 4: width of the step-count fields (0 to 2^STEP_W−1 steps per job).

Ports:
- `Clk`, in, 1: single clock, rising edge.
- `Reset`, in, 1: synchronous, active-high; one clock, synchronous active-high reset.
- `Req`, in, 2: level request per requester; held until `Ack` for that requester.
- `Steps0`, in, STEP_W: step count for requester 0; sampled at grant.
- `Steps1`, in, STEP_W: step count for requester 1; sampled at grant.
- `ClrReq`, in, 2: per-requester flag to clear the counter before stepping; sampled at grant.
- `CntOutput`, in, 3: counter `Output`.
- `CntEn`, out, 1: drives counter `En`.
- `CntReset`, out, 1: drives counter `Reset`.
- `Grant`, out, 2: one-hot owner of the counter; zero when idle.
- `Ack`, out, 2: one-cycle completion pulse per requester.
- `Result`, out, 3: counter value at job end; valid from the `Ack` cycle, held until the next job's DONE.
- `Wrapped`, out, 1: job caused at least one 4→0 wrap; same validity as `Result`.
- `Busy`, out, 1: state ≠ IDLE.

## Operation
- FSM states: IDLE, CLEAR, RUN, DONE.
- IDLE:
  - Eligible requesters are `Req[i]` with `Ack[i]` low. A requester is masked in its own `Ack` cycle.
  - Selection: if only one is eligible, take it. If both are eligible, take the one not served last. The last-served pointer resets to 1, so requester 0 wins first.
  - On selection: latch the step count into `remaining` (STEP_W bits), latch `ClrReq[i]`, set `Grant`, clear the wrap flag.
  - Next state: CLEAR if the clear flag is set, else RUN if steps ≠ 0, else DONE.
- CLEAR:
  - One cycle, `CntReset`=1.
  - Next state: RUN if `remaining` ≠ 0, else DONE.
- RUN:
  - `CntEn`=1 every cycle; `remaining` decrements each cycle.
  - If `CntOutput`==3'b100 in a RUN cycle, set the wrap flag.
  - When `remaining`==1, next state is DONE.
- DONE:
  - One cycle, `CntEn`=0.
  - Latch `Result`←`CntOutput` and `Wrapped`←wrap flag.
  - Next state IDLE; register `Ack[g]`=1 for the following cycle. `Grant` drops when IDLE is entered.
- `CntReset` = `Reset` OR (state==CLEAR). This is the only combinational output path; `CntEn` is decoded from the state.
- Requester-side `Steps`/`ClrReq` changes after grant have no effect.
- `Req` dropped mid-job has no effect: the job completes and `Ack` is still issued.

## Timing
- Reset (any state, including mid-RUN):
  - Next cycle: state IDLE, `Grant`=0, `Ack`=0, `CntEn`=0, `Result`=0, `Wrapped`=0, `Busy`=0, `remaining`=0, last-served pointer=1.
  - `CntReset`=1 while `Reset` is high.
  - An in-flight job is dropped with no `Ack`.
- Latency for steps S and clear flag C, with the request seen in IDLE at cycle 0:
  - `Grant`/`Busy` high from cycle 1.
  - CLEAR occupies cycle 1 if C=1.
  - RUN occupies S cycles.
  - DONE occupies one cycle.
  - `Ack` is at cycle S+C+2, or cycle C+2 when S=0.
- Back-to-back: the earliest next grant decision is in the `Ack` cycle, for the other requester only.
- Counter value after the job is `CntOutput` advanced by S Gray steps modulo 8; the sequence is 0,1,3,2,6,7,5,4,0.

## Test plan
- Reset, then `Req`=01, `Steps0`=3, `ClrReq`=00, counter at 0 → `CntEn` high for cycles 1–3, `Ack`=01 at cycle 5, `Result`=3'b010, `Wrapped`=0.
- `Req`=10, `ClrReq`=10, `Steps1`=0, counter at 3'b110 → `CntReset` high for exactly cycle 1, no `CntEn`, `Ack`=10 at cycle 3, `Result`=0, `Wrapped`=0.
- `Steps0`=9 from 0 → `CntOutput` passes 4→0, `Ack`=01 at cycle 11, `Result`=3'b001, `Wrapped`=1.
- After reset, `Req`=11 held with `Steps0`=`Steps1`=2:
  - Grant order 01 then 10, with `Ack` cycle masking preventing a re-grant to 01.
  - A second simultaneous pair is granted to 01 first.
- `Reset` pulsed in the second RUN cycle of a 5-step job → next cycle IDLE, all outputs 0, `Result` 0, no `Ack`. The counter is also cleared via `CntReset`.
- `Req0` held continuously with `Req1` low → jobs repeat with a single `Ack` cycle gap (IDLE/Ack cycle not re-granting 0). The next grant occurs the cycle after `Ack`.

Source files
------------

// File: rtl/gray_step_arbiter.sv
// gray_step_arbiter
// Shares one 3-bit Gray-code counter between two requesters. Each job is an
// optional counter clear followed by a number of count steps. Requesters are
// served round-robin. Each job ends with the final Gray value in Result, a
// flag in Wrapped telling whether the counter rolled over, and a one-cycle Ack.
//
// Ports:
//   Clk        in   rising-edge clock
//   Reset      in   synchronous active-high reset
//   Req[1:0]   in   level request per requester, held until its Ack
//   Steps0/1   in   step count per requester, sampled at grant
//   ClrReq[1:0] in  clear-before-stepping flag per requester, sampled at grant
//   CntOutput  in   counter Output value
//   CntEn      out  counter En (high in every RUN cycle)
//   CntReset   out  counter Reset (Reset OR clear cycle)
//   Grant[1:0] out  one-hot owner of the counter, zero when idle
//   Ack[1:0]   out  one-cycle completion pulse per requester
//   Result     out  counter value at job end
//   Wrapped    out  job stepped the counter through 4 -> 0 at least once
//   Busy       out  arbiter is not idle
module gray_step_arbiter #(
  parameter int STEP_W = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [1:0]        Req,
  input  logic [STEP_W-1:0] Steps0,
  input  logic [STEP_W-1:0] Steps1,
  input  logic [1:0]        ClrReq,
  input  logic [2:0]        CntOutput,
  output logic              CntEn,
  output logic              CntReset,
  output logic [1:0]        Grant,
  output logic [1:0]        Ack,
  output logic [2:0]        Result,
  output logic              Wrapped,
  output logic              Busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic [STEP_W-1:0]   remaining_r, remaining_s;
  logic                last_r, last_s;
  logic                wrap_r, wrap_s;
  logic [1:0]          grant_r, grant_s;
  logic [1:0]          ack_r, ack_s;
  logic [2:0]          result_r, result_s;
  logic                wrapped_r, wrapped_s;

  logic [1:0]          elig_s;
  logic                pick_s;
  logic [STEP_W-1:0]   steps_sel_s;
  logic                clr_sel_s;

  // State and datapath registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r     <= ST_IDLE;
      remaining_r <= {STEP_W{1'b0}};
      last_r      <= 1'b1;
      wrap_r      <= 1'b0;
      grant_r     <= 2'b00;
      ack_r       <= 2'b00;
      result_r    <= 3'b000;
      wrapped_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      remaining_r <= remaining_s;
      last_r      <= last_s;
      wrap_r      <= wrap_s;
      grant_r     <= grant_s;
      ack_r       <= ack_s;
      result_r    <= result_s;
      wrapped_r   <= wrapped_s;
    end
  end

  // Round-robin selection among requesters not in their own Ack cycle.
  always_comb begin
    elig_s      = Req & ~ack_r;
    pick_s      = 1'b0;
    if (elig_s == 2'b11) begin
      // Both eligible: serve the one not served last.
      pick_s = ~last_r;
    end else begin
      pick_s = elig_s[1];
    end
    steps_sel_s = pick_s ? Steps1 : Steps0;
    clr_sel_s   = ClrReq[pick_s];
  end

  // Next-state and next-register logic.
  always_comb begin
    state_s     = state_r;
    remaining_s = remaining_r;
    last_s      = last_r;
    wrap_s      = wrap_r;
    grant_s     = grant_r;
    ack_s       = 2'b00;
    result_s    = result_r;
    wrapped_s   = wrapped_r;

    case (state_r)
      ST_IDLE: begin
        if (elig_s != 2'b00) begin
          remaining_s = steps_sel_s;
          last_s      = pick_s;
          wrap_s      = 1'b0;
          grant_s     = pick_s ? 2'b10 : 2'b01;
          if (clr_sel_s) begin
            state_s = ST_CLEAR;
          end else if (steps_sel_s != {STEP_W{1'b0}}) begin
            state_s = ST_RUN;
          end else begin
            state_s = ST_DONE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (remaining_r != {STEP_W{1'b0}}) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_DONE;
        end
      end
      ST_RUN: begin
        remaining_s = remaining_r - STEP_W'(1);
        // The counter steps from 3'b100 to 3'b000 at the end of this cycle.
        if (CntOutput == 3'b100) begin
          wrap_s = 1'b1;
        end else begin
          wrap_s = wrap_r;
        end
        // Last step (the <= also guarantees RUN always terminates).
        if (remaining_r <= STEP_W'(1)) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        result_s  = CntOutput;
        wrapped_s = wrap_r;
        ack_s     = grant_r;
        grant_s   = 2'b00;
        state_s   = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        grant_s = 2'b00;
      end
    endcase
  end

  assign CntEn    = (state_r == ST_RUN);
  assign CntReset = Reset | (state_r == ST_CLEAR);
  assign Busy     = (state_r != ST_IDLE);
  assign Grant    = grant_r;
  assign Ack      = ack_r;
  assign Result   = result_r;
  assign Wrapped  = wrapped_r;

endmodule

// File: tb/tb_gray_step_arbiter.sv
// Testbench for gray_step_arbiter: models the 3-bit Gray counter, applies a
// vector table of jobs, hand sequences for reset/arbitration/back-to-back,
// and random jobs checked against a job-level reference model.
module tb_gray_step_arbiter;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [1:0] Req;
  logic [3:0] Steps0, Steps1;
  logic [1:0] ClrReq;
  logic [2:0] CntOutput;
  logic       CntEn, CntReset;
  logic [1:0] Grant, Ack;
  logic [2:0] Result;
  logic       Wrapped, Busy;

  int total = 0;
  int bad   = 0;

  gray_step_arbiter #(.STEP_W(4)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Steps0(Steps0), .Steps1(Steps1),
    .ClrReq(ClrReq), .CntOutput(CntOutput), .CntEn(CntEn), .CntReset(CntReset),
    .Grant(Grant), .Ack(Ack), .Result(Result), .Wrapped(Wrapped), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  // Gray counter model: position index 0..7 mapped through the Gray sequence.
  logic [2:0] cnt_idx = 3'd0;
  logic       preset_go = 1'b0;
  logic [2:0] preset_idx = 3'd0;

  function automatic logic [2:0] gray_of(input int idx);
    logic [2:0] tab [8];
    tab[0] = 3'b000; tab[1] = 3'b001; tab[2] = 3'b011; tab[3] = 3'b010;
    tab[4] = 3'b110; tab[5] = 3'b111; tab[6] = 3'b101; tab[7] = 3'b100;
    return tab[idx % 8];
  endfunction

  always @(posedge Clk) begin
    if (CntReset) cnt_idx <= 3'd0;
    else if (preset_go) cnt_idx <= preset_idx;
    else if (CntEn) cnt_idx <= cnt_idx + 3'd1;
  end
  assign CntOutput = gray_of(int'(cnt_idx));

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // One job from one requester; expectations supplied by caller.
  task automatic run_job(input int who, input int s, input int c, input int st,
                         input int ea, input logic [2:0] er, input logic ew,
                         input string nm);
    int ack_at = -1;
    logic [1:0] ack_val = 2'b00;
    int prof_err = 0;
    logic [1:0] oh;
    logic exp_en, exp_rst, exp_act;
    oh = (who == 1) ? 2'b10 : 2'b01;
    preset_idx = 3'(st);
    preset_go  = 1'b1;
    tick();
    preset_go  = 1'b0;
    Req        = oh;
    if (who == 1) begin Steps1 = 4'(s); Steps0 = 4'($urandom_range(0, 15)); end
    else          begin Steps0 = 4'(s); Steps1 = 4'($urandom_range(0, 15)); end
    ClrReq = (c != 0) ? oh : 2'b00;
    for (int k = 1; k <= 40; k++) begin
      tick();
      // Requester-side changes after grant must be ignored.
      if (k == 1) begin
        Steps0 = ~Steps0; Steps1 = ~Steps1; ClrReq = ~ClrReq;
      end
      exp_en  = (k >= 1 + c) && (k < 1 + c + s);
      exp_rst = (c != 0) && (k == 1);
      exp_act = (k < ea);
      if (CntEn !== exp_en || CntReset !== exp_rst || Busy !== exp_act ||
          Grant !== (exp_act ? oh : 2'b00))
        prof_err++;
      if (Ack != 2'b00) begin
        ack_at  = k;
        ack_val = Ack;
        Req     = 2'b00;
        break;
      end
    end
    Req = 2'b00;
    chk({nm, "_ack_cycle"}, 32'(ack_at), 32'(ea));
    chk({nm, "_ack_who"}, 32'(ack_val), 32'(oh));
    chk({nm, "_result"}, 32'(Result), 32'(er));
    chk({nm, "_wrapped"}, 32'(Wrapped), 32'(ew));
    chk({nm, "_profile_errs"}, 32'(prof_err), 32'd0);
  endtask

  // Both requesters ask together with 2 steps each.
  task automatic arb_pair(input string nm);
    int a0 = -1, a1 = -1;
    logic [1:0] g1 = 2'b00, g4 = 2'b11, g5 = 2'b00;
    Req = 2'b11; Steps0 = 4'd2; Steps1 = 4'd2; ClrReq = 2'b00;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 1) g1 = Grant;
      if (k == 4) g4 = Grant;
      if (k == 5) g5 = Grant;
      if (Ack[0] && a0 < 0) begin a0 = k; Req[0] = 1'b0; end
      if (Ack[1] && a1 < 0) begin a1 = k; Req[1] = 1'b0; end
    end
    Req = 2'b00;
    chk({nm, "_grant_c1"}, 32'(g1), 32'd1);
    chk({nm, "_grant_c4"}, 32'(g4), 32'd0);
    chk({nm, "_grant_c5"}, 32'(g5), 32'd2);
    chk({nm, "_ack0_cycle"}, 32'(a0), 32'd4);
    chk({nm, "_ack1_cycle"}, 32'(a1), 32'd8);
  endtask

  typedef struct {
    int who; int s; int c; int st; int ack; logic [2:0] res; logic wr;
  } vec_t;

  initial begin
    vec_t tab [7];
    int cnt;
    Reset = 1'b1; Req = 2'b00; Steps0 = 4'd0; Steps1 = 4'd0; ClrReq = 2'b00;

    tab[0] = '{0, 3, 0, 0, 5, 3'b010, 1'b0};
    tab[1] = '{1, 0, 1, 4, 3, 3'b000, 1'b0};
    tab[2] = '{0, 9, 0, 0, 11, 3'b001, 1'b1};
    tab[3] = '{1, 5, 1, 7, 8, 3'b111, 1'b0};
    tab[4] = '{0, 1, 0, 7, 3, 3'b000, 1'b1};
    tab[5] = '{1, 15, 0, 3, 17, 3'b011, 1'b1};
    tab[6] = '{0, 0, 0, 5, 2, 3'b111, 1'b0};

    tick();
    chk("rst_cntreset_high", 32'(CntReset), 32'd1);
    tick();
    Reset = 1'b0;
    #1;
    chk("rst_cntreset_low", 32'(CntReset), 32'd0);
    chk("rst_outputs", {23'd0, Grant, Ack, Result, Wrapped, Busy, CntEn}, 32'd0);

    for (int i = 0; i < 7; i++)
      run_job(tab[i].who, tab[i].s, tab[i].c, tab[i].st, tab[i].ack,
              tab[i].res, tab[i].wr, $sformatf("vec%0d", i));

    // Reset in the second RUN cycle of a 5-step job.
    preset_idx = 3'd3; preset_go = 1'b1; tick(); preset_go = 1'b0;
    Req = 2'b01; Steps0 = 4'd5; ClrReq = 2'b00;
    tick();
    tick();
    chk("midrst_busy_before", 32'(Busy & CntEn), 32'd1);
    Reset = 1'b1; Req = 2'b00;
    #1;
    chk("midrst_cntreset", 32'(CntReset), 32'd1);
    tick();
    Reset = 1'b0;
    #1;
    chk("midrst_outputs", {23'd0, Grant, Ack, Result, Wrapped, Busy, CntEn}, 32'd0);
    chk("midrst_counter_cleared", 32'(CntOutput), 32'd0);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (Ack != 2'b00 || Busy) cnt++;
    end
    chk("midrst_no_ack", 32'(cnt), 32'd0);

    // Fresh reset, then two simultaneous pairs.
    Reset = 1'b1; tick(); Reset = 1'b0;
    arb_pair("pair1");
    arb_pair("pair2");

    // Requester 0 held continuously: Ack cycle masks re-grant.
    begin
      int a_first = -1, a_second = -1;
      logic [1:0] g3 = 2'b11, g4 = 2'b11, g5 = 2'b00;
      Req = 2'b01; Steps0 = 4'd1; ClrReq = 2'b00;
      for (int k = 1; k <= 12; k++) begin
        tick();
        if (k == 3) g3 = Grant;
        if (k == 4) g4 = Grant;
        if (k == 5) g5 = Grant;
        if (Ack[0]) begin
          if (a_first < 0) a_first = k;
          else if (a_second < 0) begin a_second = k; Req = 2'b00; end
        end
      end
      Req = 2'b00;
      chk("hold_ack1_cycle", 32'(a_first), 32'd3);
      chk("hold_ack2_cycle", 32'(a_second), 32'd7);
      chk("hold_grant_c3", 32'(g3), 32'd0);
      chk("hold_grant_c4", 32'(g4), 32'd0);
      chk("hold_grant_c5", 32'(g5), 32'd1);
    end

    // Random jobs against the job-level model.
    for (int n = 0; n < 40; n++) begin
      int who, s, c, st, pos;
      who = int'($urandom_range(0, 1));
      s   = int'($urandom_range(0, 15));
      c   = int'($urandom_range(0, 1));
      st  = int'($urandom_range(0, 7));
      pos = ((c != 0) ? 0 : st) + s;
      run_job(who, s, c, st, s + c + 2, gray_of(pos), (pos >= 8),
              $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
